sram_memory_set: RTL and testbench

SRAM_MEMORY_SET -- requirements
Module: sram_memory_set

---
 rtl/sram_memory_set.sv | 78 +++++++
 tb/tb_sram_memory_set.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_memory_set.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_memory_set
//
// Purpose:
//   Memory set for a graph-processing datapath. It holds three storage arrays:
//     GraphReg  : DEPTH x GM_W, read-only, two independent asynchronous reads.
//     InputReg  : DEPTH x IM_W, read-only, one asynchronous read.
//     OutputReg : DEPTH x OM_W, one asynchronous read, one synchronous write.
//   GraphReg and InputReg are never written by logic. Their contents come from
//   an external preload through a hierarchical reference to the array.
//   None of the arrays is cleared, so every word stays X until something loads
//   or writes it.
//
// Ports:
//   clock  in   1       sole clock; OutputReg writes happen on its rising edge
//   reset  in   1       synchronous, active-high; only suppresses writes
//   GMAR1  in   ADDR_W  graph read address, port 1
//   GMDR1  out  GM_W    graph read data, port 1 (combinational)
//   GMAR2  in   ADDR_W  graph read address, port 2
//   GMDR2  out  GM_W    graph read data, port 2 (combinational)
//   IMAR   in   ADDR_W  input memory read address
//   IMDR   out  IM_W    input memory read data (combinational)
//   OMWE   in   1       output memory write enable
//   OMWAR  in   ADDR_W  output memory write address
//   OMWDR  in   OM_W    output memory write data
//   OMAR   in   ADDR_W  output memory read address
//   OMDR   out  OM_W    output memory read data (combinational)
// -----------------------------------------------------------------------------
module sram_memory_set #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192,
  parameter int GM_W   = 128,
  parameter int IM_W   = 8,
  parameter int OM_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] GMAR1,
  output logic [GM_W-1:0]   GMDR1,
  input  logic [ADDR_W-1:0] GMAR2,
  output logic [GM_W-1:0]   GMDR2,
  input  logic [ADDR_W-1:0] IMAR,
  output logic [IM_W-1:0]   IMDR,
  input  logic              OMWE,
  input  logic [ADDR_W-1:0] OMWAR,
  input  logic [OM_W-1:0]   OMWDR,
  input  logic [ADDR_W-1:0] OMAR,
  output logic [OM_W-1:0]   OMDR
);

  // Storage arrays. Their names are part of the external contract because
  // preload and dump routines reach them hierarchically.
  logic [GM_W-1:0] GraphReg  [0:DEPTH-1];
  logic [IM_W-1:0] InputReg  [0:DEPTH-1];
  logic [OM_W-1:0] OutputReg [0:DEPTH-1];

  // The read paths are purely combinational and add no cycle of latency.
  // DEPTH equals 2**ADDR_W, so every address value selects one word and no
  // range check is needed. The two graph ports are fully independent and
  // return the same word when GMAR1 == GMAR2.
  assign GMDR1 = GraphReg[GMAR1];
  assign GMDR2 = GraphReg[GMAR2];
  assign IMDR  = InputReg[IMAR];

  // There is no write-to-read bypass. A read of the address being written
  // returns the old word until the edge and the new word after it.
  assign OMDR  = OutputReg[OMAR];

  // Output memory write port. Reset gates the write and leaves the array
  // contents as they are.
  always_ff @(posedge clock) begin
    if (!reset && OMWE) begin
      OutputReg[OMWAR] <= OMWDR;
    end
  end

endmodule

// File: tb/tb_sram_memory_set.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sram_memory_set
//
// Purpose:
//   Directed, self-checking bench for sram_memory_set. The stimulus process
//   drives inputs just after a rising edge and pushes the hand-computed
//   expected value for one read port into a queue. A separate monitor
//   process samples the DUT on every falling edge, pops the pending
//   expectations and compares them against the selected read port.
// -----------------------------------------------------------------------------
module tb_sram_memory_set;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 8192;
  localparam int GM_W   = 128;
  localparam int IM_W   = 8;
  localparam int OM_W   = 16;

  localparam logic [1:0] P_GM1 = 2'd0;
  localparam logic [1:0] P_GM2 = 2'd1;
  localparam logic [1:0] P_IM  = 2'd2;
  localparam logic [1:0] P_OM  = 2'd3;

  logic              clock;
  logic              reset;
  logic [ADDR_W-1:0] GMAR1, GMAR2, IMAR, OMWAR, OMAR;
  logic [GM_W-1:0]   GMDR1, GMDR2;
  logic [IM_W-1:0]   IMDR;
  logic              OMWE;
  logic [OM_W-1:0]   OMWDR, OMDR;

  typedef struct {
    logic [1:0]      port;
    logic [GM_W-1:0] exp;
    string           name;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  sram_memory_set #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .GM_W(GM_W), .IM_W(IM_W), .OM_W(OM_W)
  ) dut (
    .clock(clock), .reset(reset),
    .GMAR1(GMAR1), .GMDR1(GMDR1),
    .GMAR2(GMAR2), .GMDR2(GMDR2),
    .IMAR(IMAR),   .IMDR(IMDR),
    .OMWE(OMWE),   .OMWAR(OMWAR), .OMWDR(OMWDR),
    .OMAR(OMAR),   .OMDR(OMDR)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: on every falling edge, score all pending expectations.
  initial begin
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [GM_W-1:0] act;
        e = exp_q.pop_front();
        case (e.port)
          P_GM1:   act = GMDR1;
          P_GM2:   act = GMDR2;
          P_IM:    act = {{(GM_W-IM_W){1'b0}}, IMDR};
          default: act = {{(GM_W-OM_W){1'b0}}, OMDR};
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  // Watchdog bound on the whole run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 ns");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Queue one expectation; the monitor scores it at the coming falling edge.
  task automatic expect_val(input logic [1:0] port, input logic [GM_W-1:0] exp,
                            input string name);
    exp_t e;
    e.port = port;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Let the monitor score what was queued, then return before the next edge.
  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  // One committed output-memory write, with reset low.
  task automatic om_write(input logic [ADDR_W-1:0] a, input logic [OM_W-1:0] d);
    OMWE  = 1'b1;
    OMWAR = a;
    OMWDR = d;
    step();
    OMWE  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    OMWE   = 1'b0;
    GMAR1  = 13'd0; GMAR2 = 13'd0; IMAR = 13'd0;
    OMWAR  = 13'd0; OMWDR = 16'h0000; OMAR = 13'd0;

    // Preload the read-only arrays straight into the DUT.
    dut.GraphReg[5]    = 128'h1;
    dut.GraphReg[6]    = 128'hFF;
    dut.InputReg[0]    = 8'h0A;
    dut.InputReg[8191] = 8'h3C;

    step();
    step();

    // Reads track their contents while reset is held.
    GMAR1 = 13'd5; GMAR2 = 13'd6; IMAR = 13'd0;
    expect_val(P_GM1, 128'h1, "reset_gm1_track");
    expect_val(P_IM,  128'h0A, "reset_im_track");
    settle();
    reset = 1'b0;
    step();

    // Dual graph read, different addresses, then the same address.
    GMAR1 = 13'd5; GMAR2 = 13'd6;
    expect_val(P_GM1, 128'h1,  "gm_dual_port1");
    expect_val(P_GM2, 128'hFF, "gm_dual_port2");
    settle();
    GMAR1 = 13'd6; GMAR2 = 13'd6;
    expect_val(P_GM1, 128'hFF, "gm_same_addr_port1");
    expect_val(P_GM2, 128'hFF, "gm_same_addr_port2");
    settle();

    // Input reads at both ends of the address range.
    IMAR = 13'd0;
    expect_val(P_IM, 128'h0A, "im_addr0");
    settle();
    IMAR = 13'd8191;
    expect_val(P_IM, 128'h3C, "im_addr8191");
    settle();

    // Output write/read: old data before the edge, new data after it.
    step();
    om_write(13'd3, 16'h0011);
    OMWE = 1'b1; OMWAR = 13'd3; OMWDR = 16'hFFFF; OMAR = 13'd3;
    expect_val(P_OM, 128'h0011, "om_old_before_edge");
    settle();
    step();
    OMWE = 1'b0; OMWDR = 16'h1234;
    expect_val(P_OM, 128'hFFFF, "om_new_after_edge");
    settle();
    step();
    expect_val(P_OM, 128'hFFFF, "om_we0_ignored");
    settle();

    // Reset suppresses writes, then a write commits once reset drops.
    step();
    om_write(13'd7, 16'h0005);
    reset = 1'b1; OMWE = 1'b1; OMWAR = 13'd7; OMWDR = 16'h0009; OMAR = 13'd7;
    step();
    expect_val(P_OM, 128'h0005, "reset_suppress_edge1");
    settle();
    step();
    expect_val(P_OM, 128'h0005, "reset_suppress_edge2");
    settle();
    reset = 1'b0;
    step();
    OMWE = 1'b0;
    expect_val(P_OM, 128'h0009, "reset_release_commit");
    settle();

    // Boundary addresses, checked for aliasing.
    step();
    om_write(13'd0, 16'hAAAA);
    om_write(13'd8191, 16'h5555);
    OMAR = 13'd0;
    expect_val(P_OM, 128'hAAAA, "om_boundary_addr0");
    settle();
    OMAR = 13'd8191;
    expect_val(P_OM, 128'h5555, "om_boundary_addr8191");
    settle();
    OMAR = 13'd3;
    expect_val(P_OM, 128'hFFFF, "om_addr3_untouched");
    settle();

    step();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left unscored, expected 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
